// File: rtl/tespar_pkg.sv
// Shared widths, constants and default alphabet tables for the TESPAR codebook
// encoder. The defaults are used by software (and the bench) to load the
// run-time tables; the hardware itself resets both tables to zero.
package tespar_pkg;

    // Default widths / geometry
    localparam int DEF_D_W        = 6;
    localparam int DEF_S_W        = 5;
    localparam int DEF_CODE_W     = 5;
    localparam int DEF_BAND_W     = 3;
    localparam int DEF_S_COLS     = 6;
    localparam int DEF_D_MAX      = 37;
    localparam int DEF_HIST_CNT_W = 16;

    localparam int DEF_COL_W      = $clog2(DEF_S_COLS);
    localparam int DEF_CODE_DEPTH = (1 << DEF_BAND_W) * DEF_S_COLS;
    localparam int DEF_CFG_ADDR_W = (DEF_D_W > DEF_BAND_W + DEF_COL_W) ? DEF_D_W
                                                                       : DEF_BAND_W + DEF_COL_W;
    localparam int DEF_CFG_DATA_W = (DEF_BAND_W > DEF_CODE_W) ? DEF_BAND_W : DEF_CODE_W;

    // Code 0 is reserved for "no symbol"
    localparam logic [DEF_CODE_W-1:0] CODE_NONE = '0;

    // Config table select
    localparam logic CFG_SEL_BAND = 1'b0;
    localparam logic CFG_SEL_CODE = 1'b1;

    // Standard 28-symbol alphabet: duration band for a legal duration d (1..D_MAX)
    function automatic logic [DEF_BAND_W-1:0] default_band(input int d);
        logic [DEF_BAND_W-1:0] b;
        if      (d <= 1)  b = 3'd0;
        else if (d == 2)  b = 3'd1;
        else if (d == 3)  b = 3'd2;
        else if (d <= 5)  b = 3'd3;
        else if (d <= 8)  b = 3'd4;
        else if (d <= 12) b = 3'd5;
        else if (d <= 20) b = 3'd6;
        else              b = 3'd7;
        return b;
    endfunction

    // Standard 28-symbol alphabet: code for (band, clamped shape column).
    // Each band owns a contiguous run of codes; columns past the run reuse its last code.
    function automatic logic [DEF_CODE_W-1:0] default_code(input int band, input int col);
        int base;
        int size;
        int c;
        case (band)
            0:       begin base = 1;  size = 1; end
            1:       begin base = 2;  size = 2; end
            2:       begin base = 4;  size = 3; end
            3:       begin base = 7;  size = 4; end
            4:       begin base = 11; size = 4; end
            5:       begin base = 15; size = 5; end
            6:       begin base = 20; size = 5; end
            default: begin base = 25; size = 4; end
        endcase
        c = (col >= size) ? size - 1 : col;
        return DEF_CODE_W'(base + c);
    endfunction

endpackage

// File: rtl/tespar_codebook_encoder_hist.sv
// Histogram counter bank: one saturating counter per code value, a synchronous
// clear that wins over a same-cycle increment, and a registered read port.
// Only instantiated when TESPAR_HIST_EN is defined.
module tespar_code_hist #(
    parameter int CODE_W = 5,
    parameter int CNT_W  = 16
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_inc,
    input  logic [CODE_W-1:0] i_code,
    input  logic              i_clr,
    input  logic [CODE_W-1:0] i_addr,
    output logic [CNT_W-1:0]  o_data
);

    localparam int N_CNT = 1 << CODE_W;

    logic [CNT_W-1:0] r_cnt [0:N_CNT-1];
    logic [CNT_W-1:0] r_data;

    // Counter bank: clear has priority, increments saturate at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CNT; i++) r_cnt[i] <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < N_CNT; i++) r_cnt[i] <= '0;
        end else if (i_inc && (r_cnt[i_code] != '1)) begin
            r_cnt[i_code] <= r_cnt[i_code] + 1'b1;
        end
    end

    // Registered read port, one cycle of latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_data <= '0;
        else        r_data <= r_cnt[i_addr];
    end

    assign o_data = r_data;

endmodule

// File: rtl/tespar_codebook_encoder.sv
// TESPAR codebook encoder: maps (duration D, shape S) epoch descriptors to
// alphabet codes via a loadable band table (D -> band) and a loadable code
// table ((band, clamped S) -> code). Two register stages, 1 symbol/clock.
//
// Handshake: a transfer happens on a port when valid && ready at a rising
// edge. in_ready = !out_valid || out_ready; while out_valid && !out_ready the
// whole pipeline holds and out_* stay stable.
//
// Optional histogram: define TESPAR_HIST_EN to add hist_clr/hist_addr/hist_data.
module tespar_codebook_encoder
    import tespar_pkg::*;
#(
    parameter int D_W        = DEF_D_W,
    parameter int S_W        = DEF_S_W,
    parameter int CODE_W     = DEF_CODE_W,
    parameter int BAND_W     = DEF_BAND_W,
    parameter int S_COLS     = DEF_S_COLS,
`ifdef TESPAR_HIST_EN
    parameter int HIST_CNT_W = DEF_HIST_CNT_W,
`endif
    parameter int D_MAX      = DEF_D_MAX,
    localparam int COL_W      = $clog2(S_COLS),
    localparam int CFG_ADDR_W = (D_W > BAND_W + COL_W) ? D_W : BAND_W + COL_W,
    localparam int CFG_DATA_W = (BAND_W > CODE_W) ? BAND_W : CODE_W
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [D_W-1:0]        in_d,
    input  logic [S_W-1:0]        in_s,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CODE_W-1:0]     out_code,
    output logic                  out_err,
`ifdef TESPAR_HIST_EN
    input  logic                  hist_clr,
    input  logic [CODE_W-1:0]     hist_addr,
    output logic [HIST_CNT_W-1:0] hist_data,
`endif
    input  logic                  cfg_we,
    input  logic                  cfg_sel,
    input  logic [CFG_ADDR_W-1:0] cfg_addr,
    input  logic [CFG_DATA_W-1:0] cfg_data
);

    localparam int CODE_DEPTH = (1 << BAND_W) * S_COLS;
    localparam int IDX_W      = $clog2(CODE_DEPTH);

    localparam logic [D_W-1:0]        D_LAST        = D_W'(D_MAX);
    localparam logic [S_W-1:0]        S_LAST        = S_W'(S_COLS - 1);
    localparam logic [COL_W-1:0]      COL_LAST      = COL_W'(S_COLS - 1);
    localparam logic [CFG_ADDR_W-1:0] BAND_ADDR_MAX = CFG_ADDR_W'(D_MAX);
    localparam logic [CFG_ADDR_W-1:0] CODE_ADDR_END = CFG_ADDR_W'(CODE_DEPTH);

    // Tables
    logic [BAND_W-1:0] r_band_tbl [0:D_MAX];
    logic [CODE_W-1:0] r_code_tbl [0:CODE_DEPTH-1];

    // Stage 1
    logic              r_v1;
    logic              r_err1;
    logic [BAND_W-1:0] r_band1;
    logic [COL_W-1:0]  r_col1;

    // Stage 2 (output)
    logic              r_out_valid;
    logic [CODE_W-1:0] r_out_code;
    logic              r_out_err;

    // Combinational
    logic              w_en;
    logic              w_err0;
    logic [BAND_W-1:0] w_band0;
    logic [COL_W-1:0]  w_col0;
    logic [IDX_W-1:0]  w_code_idx;
    logic [CODE_W-1:0] w_code1;

    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    // Table writes land at the edge regardless of stall; out-of-range addresses are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= D_MAX; i++)     r_band_tbl[i] <= '0;
            for (int i = 0; i < CODE_DEPTH; i++) r_code_tbl[i] <= '0;
        end else if (cfg_we) begin
            if (cfg_sel == CFG_SEL_BAND) begin
                if (cfg_addr <= BAND_ADDR_MAX) r_band_tbl[cfg_addr] <= cfg_data[BAND_W-1:0];
            end else begin
                if (cfg_addr < CODE_ADDR_END)  r_code_tbl[cfg_addr] <= cfg_data[CODE_W-1:0];
            end
        end
    end

    // Stage-1 decode: range check, band lookup (only for legal D), saturating shape clamp
    always_comb begin
        w_err0  = (in_d == '0) || (in_d > D_LAST);
        w_band0 = '0;
        if (!w_err0) w_band0 = r_band_tbl[in_d];
        w_col0  = (in_s >= S_LAST) ? COL_LAST : in_s[COL_W-1:0];
    end

    // Stage-1 register: bubbles shift in as v1=0, payload only loads with a real descriptor
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_err1  <= 1'b0;
            r_band1 <= '0;
            r_col1  <= '0;
        end else if (w_en) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_err1  <= w_err0;
                r_band1 <= w_band0;
                r_col1  <= w_col0;
            end
        end
    end

    // Stage-2 code lookup: linear index band*S_COLS+col, forced to "no symbol" on range error
    always_comb begin
        w_code_idx = IDX_W'(r_band1) * IDX_W'(S_COLS) + IDX_W'(r_col1);
        w_code1    = r_err1 ? CODE_W'(CODE_NONE) : r_code_tbl[w_code_idx];
    end

    // Stage-2 / output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_code  <= '0;
            r_out_err   <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_v1;
            r_out_code  <= w_code1;
            r_out_err   <= r_err1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_code  = r_out_code;
    assign out_err   = r_out_err;

`ifdef TESPAR_HIST_EN
    logic w_hist_inc;
    assign w_hist_inc = r_out_valid && out_ready && !r_out_err;

    tespar_code_hist #(
        .CODE_W (CODE_W),
        .CNT_W  (HIST_CNT_W)
    ) u_hist (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_inc  (w_hist_inc),
        .i_code (r_out_code),
        .i_clr  (hist_clr),
        .i_addr (hist_addr),
        .o_data (hist_data)
    );
`endif

endmodule

// File: tb/tb_tespar_codebook_encoder.sv
// Bench for tespar_codebook_encoder: driver tasks, a negedge monitor holding a
// reference copy of both tables, and an expected-result queue.
module tb_tespar_codebook_encoder;
  import tespar_pkg::*;

  localparam int EW = DEF_CODE_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                      in_valid = 1'b0;
  logic                      in_ready;
  logic [DEF_D_W-1:0]        in_d = '0;
  logic [DEF_S_W-1:0]        in_s = '0;
  logic                      out_valid;
  logic                      out_ready = 1'b1;
  logic [DEF_CODE_W-1:0]     out_code;
  logic                      out_err;
  logic                      cfg_we = 1'b0;
  logic                      cfg_sel = 1'b0;
  logic [DEF_CFG_ADDR_W-1:0] cfg_addr = '0;
  logic [DEF_CFG_DATA_W-1:0] cfg_data = '0;
`ifdef TESPAR_HIST_EN
  logic                      hist_clr = 1'b0;
  logic [DEF_CODE_W-1:0]     hist_addr = '0;
  logic [DEF_HIST_CNT_W-1:0] hist_data;
`endif

  tespar_codebook_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_d      (in_d),
    .in_s      (in_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_err   (out_err),
`ifdef TESPAR_HIST_EN
    .hist_clr  (hist_clr),
    .hist_addr (hist_addr),
    .hist_data (hist_data),
`endif
    .cfg_we    (cfg_we),
    .cfg_sel   (cfg_sel),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [EW-1:0] exp_q[$];
  int m_band [0:DEF_D_MAX];
  int m_code [0:DEF_CODE_DEPTH-1];
  bit prev_stall = 1'b0;
  logic [EW:0] prev_out = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: {err, code} for a descriptor using the bench's table copy
  function automatic logic [EW-1:0] model(input int d, input int s);
    logic err;
    int band;
    int col;
    int code;
    err  = (d == 0) || (d > DEF_D_MAX);
    band = 0;
    if (!err) band = m_band[d];
    col  = (s > DEF_S_COLS - 1) ? DEF_S_COLS - 1 : s;
    code = 0;
    if (!err) code = m_code[band * DEF_S_COLS + col];
    return {err, DEF_CODE_W'(code)};
  endfunction

  // Monitor: sample on negedge, everything stable for the next rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i <= DEF_D_MAX; i++) m_band[i] = 0;
      for (int i = 0; i < DEF_CODE_DEPTH; i++) m_code[i] = 0;
      prev_stall = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          check("out_code", 32'(out_code), 32'(e[DEF_CODE_W-1:0]));
          check("out_err", 32'(out_err), 32'(e[DEF_CODE_W]));
        end
      end
      if (prev_stall) check("stall_hold", 32'({out_valid, out_err, out_code}), 32'(prev_out));
      if (out_valid && !out_ready) begin
        check("stall_in_ready", 32'(in_ready), 0);
        prev_stall = 1'b1;
        prev_out   = {out_valid, out_err, out_code};
      end else begin
        prev_stall = 1'b0;
      end
      // Acceptance uses the tables as they are before this edge's config write
      if (in_valid && in_ready) exp_q.push_back(model(int'(in_d), int'(in_s)));
      if (cfg_we) begin
        if (cfg_sel == CFG_SEL_BAND) begin
          if (int'(cfg_addr) <= DEF_D_MAX) m_band[cfg_addr] = int'(cfg_data) & 7;
        end else begin
          if (int'(cfg_addr) < DEF_CODE_DEPTH) m_code[cfg_addr] = int'(cfg_data) & 31;
        end
      end
    end
  end

  // ---------------- driver tasks (enter/leave at posedge+1) ----------------
  task automatic cfg_write(input logic sel, input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_sel  = sel;
    cfg_addr = DEF_CFG_ADDR_W'(addr);
    cfg_data = DEF_CFG_DATA_W'(data);
    @(posedge clk); #1;
    cfg_we   = 1'b0;
  endtask

  task automatic send(input int d, input int s);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_d     = DEF_D_W'(d);
    in_s     = DEF_S_W'(s);
    @(negedge clk);
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) check("send_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Watchdog
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  bit stream_done;

  // ---------------- test sequence ----------------
  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_code", 32'(out_code), 0);
    check("rst_out_err", 32'(out_err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Basic mapping and 2-cycle latency
    cfg_write(CFG_SEL_BAND, 8, 1);
    cfg_write(CFG_SEL_CODE, 6, 7);
    cfg_write(CFG_SEL_CODE, 7, 8);
    cfg_write(CFG_SEL_BAND, 40, 5);   // beyond D_MAX: ignored
    cfg_write(CFG_SEL_CODE, 50, 3);   // beyond code depth: ignored
    cfg_write(CFG_SEL_BAND, 10, 30);  // upper data bits dropped -> band 6
    send(8, 0);
    idle();
    @(negedge clk);
    check("lat_cycle1_valid", 32'(out_valid), 0);
    @(negedge clk);
    check("lat_cycle2_valid", 32'(out_valid), 1);
    check("lat_cycle2_code", 32'(out_code), 7);
    check("lat_cycle2_err", 32'(out_err), 0);
    drain();

    // Shape clamp, back-to-back
    cfg_write(CFG_SEL_CODE, 11, 9);
    send(8, 1);
    send(8, 20);
    idle();
    drain();

    // Range errors and boundaries
    cfg_write(CFG_SEL_BAND, 37, 3);
    cfg_write(CFG_SEL_CODE, 18, 12);
    cfg_write(CFG_SEL_CODE, 2, 5);
    cfg_write(CFG_SEL_CODE, 6 * 6 + 5, 21);
    send(0, 3);
    send(38, 0);
    send(37, 0);
    send(1, 2);
    send(10, 31);
    send(63, 5);
    idle();
    drain();

`ifdef TESPAR_HIST_EN
    hist_clr = 1'b1;
    @(posedge clk); #1;
    hist_clr = 1'b0;
    send(8, 0); send(8, 0); send(8, 0); send(8, 1);
    send(0, 0); send(38, 0);
    idle();
    drain();
    hist_addr = 7;
    @(posedge clk); #1;
    check("hist_code7", 32'(hist_data), 3);
    hist_addr = 8;
    @(posedge clk); #1;
    check("hist_code8", 32'(hist_data), 1);
    hist_addr = 0;
    @(posedge clk); #1;
    check("hist_code0", 32'(hist_data), 0);
    hist_clr = 1'b1;
    @(posedge clk); #1;
    hist_clr = 1'b0;
    hist_addr = 7;
    @(posedge clk); #1;
    check("hist_clr_code7", 32'(hist_data), 0);
`endif

    // Stall: 4 descriptors, out_ready low for 5 cycles after the first output
    fork
      begin
        send(8, 0); send(8, 1); send(8, 5); send(10, 2);
        idle();
      end
      begin
        int k;
        k = 0;
        @(negedge clk);
        while (!out_valid && k < 50) begin
          @(negedge clk);
          k++;
        end
        check("stall_first_out", 32'(out_valid), 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Band write in the same cycle as a D=9 acceptance
    cfg_write(CFG_SEL_BAND, 9, 1);
    cfg_write(CFG_SEL_CODE, 6, 3);
    cfg_write(CFG_SEL_CODE, 12, 4);
    cfg_we = 1'b1; cfg_sel = CFG_SEL_BAND; cfg_addr = 9; cfg_data = 2;
    send(9, 0);
    cfg_we = 1'b0;
    send(9, 0);
    idle();
    drain();

    // Random tables and a random stream with random backpressure
    for (int d = 1; d <= DEF_D_MAX; d++) cfg_write(CFG_SEL_BAND, d, $urandom_range(0, 7));
    for (int i = 0; i < DEF_CODE_DEPTH; i++) cfg_write(CFG_SEL_CODE, i, $urandom_range(1, 31));
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send($urandom_range(0, 45), $urandom_range(0, 31));
          if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk); #1;
          end
        end
        idle();
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-stream: in-flight symbols dropped, tables cleared
    send(8, 0);
    send(8, 1);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(8, 0);
    idle();
    @(negedge clk);
    @(negedge clk);
    check("midrst_valid", 32'(out_valid), 1);
    check("midrst_code", 32'(out_code), 0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
